// File: rtl/sin_sqrt_core.sv
// sin_sqrt_core: 2-cycle quarter-wave sine (optional cosine via SIN_SQRT_COS_EN) and 12-stage pipelined integer sqrt.
module sin_sqrt_core (
  input  logic        CK_i,
  input  logic        SRST_i,
  input  logic [11:0] DAT_i,
  output logic [11:0] SIN_o,
  output logic [11:0] COS_o,
  input  logic [22:0] DATs_i,
  input  logic        SQ_VLD_i,
  output logic [11:0] QQs_o,
  output logic        SQ_VLD_o
);
  function automatic logic [10:0] qsin(input int k);
    real x, t, s;
    x = 6.283185307179586 * real'(k) / 4096.0;
    t = x;
    s = x;
    for (int n = 1; n < 13; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return 11'($rtoi(2047.0 * s + 0.5));
  endfunction
  logic [10:0] rom [1025];
  for (genvar k = 0; k < 1025; k++) begin : g_rom
    localparam logic [10:0] V = qsin(k);
    assign rom[k] = V;
  end
  logic [1:0] q;
  logic [9:0] a;
  logic [10:0] sia, sw_d, sw_q;
  logic [11:0] sin_d, sin_q;
  logic sn_q;
  always_comb begin
    q = DAT_i[11:10];
    a = DAT_i[9:0];
    sia = q[0] ? 11'd1024 - {1'b0, a} : {1'b0, a};
    sw_d = rom[sia];
    sin_d = sn_q ? -{1'b0, sw_q} : {1'b0, sw_q};
  end
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      sw_q <= '0;
      sn_q <= 1'b0;
      sin_q <= '0;
    end else begin
      sw_q <= sw_d;
      sn_q <= q[1];
      sin_q <= sin_d;
    end
  end
  assign SIN_o = sin_q;
`ifdef SIN_SQRT_COS_EN
  // cosine reads the same ROM with the quadrant advanced by one
  logic [1:0] qc;
  logic [10:0] cia, cw_d, cw_q;
  logic [11:0] cos_d, cos_q;
  logic cn_q;
  always_comb begin
    qc = q + 2'd1;
    cia = qc[0] ? 11'd1024 - {1'b0, a} : {1'b0, a};
    cw_d = rom[cia];
    cos_d = cn_q ? -{1'b0, cw_q} : {1'b0, cw_q};
  end
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      cw_q <= '0;
      cn_q <= 1'b0;
      cos_q <= '0;
    end else begin
      cw_q <= cw_d;
      cn_q <= qc[1];
      cos_q <= cos_d;
    end
  end
  assign COS_o = cos_q;
`else
  assign COS_o = '0;
`endif
  // each stage tries root bit B: remainder holds x - root^2, trial is 2*root*2^B + 4^B
  for (genvar s = 0; s < 12; s++) begin : g_sq
    localparam int B = 11 - s;
    logic [22:0] rem_in, rem_d;
    logic [11:0] root_in, root_d, root_q;
    logic vld_in, vld_q, ge;
    logic [24:0] trial;
    if (s == 0) begin : g_in
      assign rem_in = DATs_i;
      assign root_in = '0;
      assign vld_in = SQ_VLD_i;
    end else begin : g_in
      assign rem_in = g_sq[s-1].g_r.rem_q;
      assign root_in = g_sq[s-1].root_q;
      assign vld_in = g_sq[s-1].vld_q;
    end
    always_comb begin
      trial = (25'(root_in) << (B + 1)) | (25'(1) << (2 * B));
      ge = {2'b00, rem_in} >= trial;
      rem_d = ge ? 23'({2'b00, rem_in} - trial) : rem_in;
      root_d = root_in | (12'(ge) << B);
    end
    always_ff @(posedge CK_i) begin
      if (SRST_i) begin
        root_q <= '0;
        vld_q <= 1'b0;
      end else begin
        root_q <= root_d;
        vld_q <= vld_in;
      end
    end
    if (s < 11) begin : g_r
      logic [22:0] rem_q;
      always_ff @(posedge CK_i) rem_q <= SRST_i ? '0 : rem_d;
    end
  end
  assign QQs_o = g_sq[11].root_q;
  assign SQ_VLD_o = g_sq[11].vld_q;
endmodule

// File: tb/tb_sin_sqrt_core.sv
// tb_sin_sqrt_core: directed and streaming checks of the sine and sqrt pipelines against a delay-line reference.
module tb_sin_sqrt_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [11:0] dat, sin_o, cos_o, qq;
  logic [22:0] dats;
  logic vi, vo;
  int total = 0;
  int bad = 0;
  int sp[2], cp[2], php[2], sx[12];
  bit sv[12];
  int sw[4096];
  int card_p[5] = '{'h000, 'h400, 'h800, 'hC00, 'h200};
  int card_s[5] = '{0, 2047, 0, -2047, 1447};
  int card_c[5] = '{2047, 0, -2047, 0, 1447};
  int corn_x[7] = '{0, 1, 3, 4, 'h7FFFFF, 8386816, 8386815};
  int corn_q[7] = '{0, 1, 1, 2, 2896, 2896, 2895};

  sin_sqrt_core dut (
    .CK_i(clk), .SRST_i(rst), .DAT_i(dat), .SIN_o(sin_o), .COS_o(cos_o),
    .DATs_i(dats), .SQ_VLD_i(vi), .QQs_o(qq), .SQ_VLD_o(vo)
  );

  function automatic int ref_trig(input int p, input bit c);
    real w = 6.283185307179586 * real'(p) / 4096.0;
    real v = 2047.0 * (c ? $cos(w) : $sin(w));
    return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    int q;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin sp[i] = 0; cp[i] = 0; php[i] = -1; end
      for (int i = 0; i < 12; i++) begin sx[i] = 0; sv[i] = 1'b0; end
    end else begin
      sp[1] = sp[0]; cp[1] = cp[0]; php[1] = php[0];
      sp[0] = ref_trig(int'(dat), 1'b0);
      cp[0] = ref_trig(int'(dat), 1'b1);
      php[0] = int'(dat);
      for (int i = 11; i > 0; i--) begin sx[i] = sx[i-1]; sv[i] = sv[i-1]; end
      sx[0] = int'(dats);
      sv[0] = vi;
    end
    @(negedge clk);
    chk("sin", int'($signed(sin_o)), sp[1]);
`ifdef SIN_SQRT_COS_EN
    chk("cos", int'($signed(cos_o)), cp[1]);
`else
    chk("cos_off", int'($signed(cos_o)), 0);
`endif
    if (php[1] >= 0) sw[php[1]] = int'($signed(sin_o));
    q = int'(qq);
    chk("sq_bound", int'((q * q <= sx[11]) && (sx[11] < (q + 1) * (q + 1))), 1);
    chk("sq_vld", int'(vo), int'(sv[11]));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin
      dat = 12'($urandom);
      dats = 23'($urandom);
      vi = 1'($urandom);
      step();
      chk("rst_sin", int'(sin_o), 0);
      chk("rst_cos", int'(cos_o), 0);
      chk("rst_qq", int'(qq), 0);
      chk("rst_vld", int'(vo), 0);
    end
    rst = 1'b0;
    vi = 1'b1;
    dats = '0;
    for (int i = 0; i < 5; i++) begin
      dat = 12'(card_p[i]);
      step();
      step();
      chk("card_sin", int'($signed(sin_o)), card_s[i]);
`ifdef SIN_SQRT_COS_EN
      chk("card_cos", int'($signed(cos_o)), card_c[i]);
`endif
    end
    for (int i = 0; i < 7; i++) begin
      dats = 23'(corn_x[i]);
      repeat (12) step();
      chk("sq_corner", int'(qq), corn_q[i]);
      chk("sq_corner_vld", int'(vo), 1);
    end
    for (int i = 0; i < 10000; i++) begin
      dat = i < 4096 ? 12'(i) : 12'($urandom);
      dats = 23'($urandom_range(0, 32'h7FFFFF));
      vi = 1'($urandom);
      rst = (i == 6000);
      step();
      if (i == 6000) begin
        chk("mid_rst_sin", int'(sin_o), 0);
        chk("mid_rst_qq", int'(qq), 0);
        chk("mid_rst_vld", int'(vo), 0);
      end
    end
    rst = 1'b0;
    repeat (12) step();
    for (int p = 1; p < 4096; p++) chk("odd_sym", sw[4096 - p], -sw[p]);
    chk("wrap_7ff", sw['h7FF], 3);
    chk("wrap_800", sw['h800], 0);
    chk("wrap_fff", sw['hFFF], -3);
    chk("wrap_000", sw[0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
